yuv_conv_arbiter: RTL and testbench
===================================

# yuv_conv_arbiter

Line-granular round-robin arbiter that shares one YUV422→gray converter between the left (source 0) and right (source 1) camera YUV streams. It sits between the two video-input AXI4-Stream paths and the converter's slave port. Ownership changes only at line boundaries (`tlast`), so lines are never interleaved. Each source is frame-aligned after reset by discarding beats until its first start-of-frame (`tuser`). Output beats carry a `tdest` tag so the converter output can be demultiplexed.

## Interface
- DATA_WIDTH, 8, pixel component width
- PPC, 4, pixels per clock; stream data width is DATA_WIDTH*PPC*3
- CNT_WIDTH, 16, width of the saturating drop counters

- aclk  in  1  clock, all logic rising-edge
- aresetn  in  1  reset, asynchronous assert, active-low
- s0_axis_yuv_tdata  in  DATA_WIDTH*PPC*3  left source data
- s0_axis_yuv_tvalid / tuser / tlast  in  1 each  left source valid, start-of-frame, end-of-line
- s0_axis_yuv_tready  out  1  left source ready
- s1_axis_yuv_* (same set)  in/out  as s0  right source
- m_axis_yuv_tdata  out  DATA_WIDTH*PPC*3  to converter
- m_axis_yuv_tvalid / tuser / tlast  out  1 each
- m_axis_yuv_tdest  out  1  source id of the current beat (0 = left, 1 = right)
- m_axis_yuv_tready  in  1  converter ready
- drop_cnt0, drop_cnt1  out  CNT_WIDTH  beats discarded per source while unsynced; saturate at all-ones

## Operation
- Per-source sync flag `sync[i]`, cleared by reset.
  - While `sync[i]`=0: `s_i_tready = !(s_i_tvalid & s_i_tuser)`. Beats accepted this way are dropped and increment `drop_cnt_i`.
  - A beat with `tuser`=1 sets `sync[i]` and is not consumed. It then waits as a normal request.
- A source requests when `sync[i] & s_i_tvalid`.
- FSM states: IDLE, GRANT0, GRANT1.
  - IDLE: if exactly one source requests, go to its GRANT state. If both request, grant `!last_grant`. If none request, stay in IDLE.
  - GRANTi: `s_i_tready` = slice input ready; the other synced source sees tready=0. A beat is accepted on `s_i_tvalid & s_i_tready`.
  - Acceptance with `tlast`=1 → IDLE and `last_grant <= i`.
- `last_grant` resets to 1, so source 0 wins the first tie.
- Accepted beats enter a 2-entry register slice together with `tdest=i`, `tuser` and `tlast`. The slice drives the m_axis port.
- `tdata`, `tuser` and `tlast` pass through unmodified.
- Unsynced drop on one source proceeds in parallel with a grant to the other source.

## Timing
- Reset values:
  - all tready = 0
  - m_axis tvalid/tuser/tlast/tdest/tdata = 0
  - drop_cnt = 0
  - state = IDLE, `sync` = 00, `last_grant` = 1
- Latency: accepted beat appears on m_axis the next cycle when the slice is empty.
- Throughput:
  - 1 beat/clk within a line.
  - Exactly one bubble cycle per line: the IDLE decision cycle, in which no source sees tready=1 unless it is unsynced.
- Slice input ready deasserts only when 2 entries are held. `m_axis_yuv_tready` low never drops or duplicates a beat.
- m_axis tvalid/tdata/tdest remain stable while tvalid=1 & tready=0.
- Simultaneous events:
  - A slice push and pop in the same cycle keeps occupancy unchanged.
  - The `tuser` beat that sets `sync` is not counted as dropped.
- Reset mid-line: all state returns to reset values immediately. Both sources must re-sync on their next `tuser`.

## Structure
- Shared package `stereo_pkg`: `arb_state_t` enum (IDLE, GRANT0, GRANT1), default DATA_WIDTH/PPC localparams.
- Sub-module `axis_reg_slice`: 2-entry skid buffer with parameterised payload width (data+tuser+tlast+tdest). It is reusable by the other stream blocks.
- Arbiter FSM, sync flags and counters live in the top module.

## Test plan
- Reset, then s0 sends 3 beats without `tuser` followed by a line starting with `tuser` → drop_cnt0=3; output holds only the `tuser` line, tdest=0, first output beat tuser=1.
- Both sources synced, each presents a 4-beat line simultaneously → order is s0 line then s1 line, 1 idle cycle between lines, tlast on beats 4 and 8.
- s0 requests continuously and s1 is idle → consecutive s0 lines, tdest=0, one bubble per line; s1 then requests → next grant goes to s1.
- Random m_axis_tready with 50% duty over 100 lines → scoreboard shows no loss, duplication or interleaving; tdest matches the origin of each beat.
- Feed 2^CNT_WIDTH+5 beats to an unsynced s1 → drop_cnt1 saturates at 0xFFFF; s0 traffic is unaffected.
- Assert aresetn low mid-line during GRANT1 → outputs return to reset values on the same edge; after release, s1 must present `tuser` again before it is granted.

Source files
------------

// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo camera stream blocks.
package stereo_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefPpc       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry AXI4-Stream skid buffer; s_ready drops only when both entries are full.
module axis_reg_slice #(
  parameter int unsigned Width = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [Width-1:0] s_payload,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [Width-1:0] m_payload
);

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] out_q, out_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             push, pop;

  assign s_ready   = !skid_valid_q;
  assign m_valid   = out_valid_q;
  assign m_payload = out_q;
  assign push      = s_valid && s_ready;
  assign pop       = out_valid_q && m_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (pop || !out_valid_q) begin
      if (skid_valid_q) begin
        // Skid full implies s_ready=0, so no push can coincide here.
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_d = s_payload;
      end
    end else if (push) begin
      skid_d       = s_payload;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/yuv_conv_arbiter.sv
// Line-granular round-robin arbiter sharing one YUV->gray converter between two
// frame-aligned camera streams; output beats are tagged with their source in tdest.
module yuv_conv_arbiter
  import stereo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned PPC        = DefPpc,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [DATA_WIDTH*PPC*3-1:0] s0_axis_yuv_tdata,
  input  logic                        s0_axis_yuv_tvalid,
  input  logic                        s0_axis_yuv_tuser,
  input  logic                        s0_axis_yuv_tlast,
  output logic                        s0_axis_yuv_tready,
  input  logic [DATA_WIDTH*PPC*3-1:0] s1_axis_yuv_tdata,
  input  logic                        s1_axis_yuv_tvalid,
  input  logic                        s1_axis_yuv_tuser,
  input  logic                        s1_axis_yuv_tlast,
  output logic                        s1_axis_yuv_tready,
  output logic [DATA_WIDTH*PPC*3-1:0] m_axis_yuv_tdata,
  output logic                        m_axis_yuv_tvalid,
  output logic                        m_axis_yuv_tuser,
  output logic                        m_axis_yuv_tlast,
  output logic                        m_axis_yuv_tdest,
  input  logic                        m_axis_yuv_tready,
  output logic [CNT_WIDTH-1:0]        drop_cnt0,
  output logic [CNT_WIDTH-1:0]        drop_cnt1
);

  localparam int unsigned TW = DATA_WIDTH * PPC * 3;
  localparam int unsigned PW = TW + 3;
  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  arb_state_t           state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [1:0]           vld, usr, lst, rdy, req, drop;
  logic                 last_grant_q, last_grant_d;
  logic                 run_q;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                 slice_ready, push_valid, m_valid;
  logic [PW-1:0]        push_payload, m_payload;

  assign vld = {s1_axis_yuv_tvalid, s0_axis_yuv_tvalid};
  assign usr = {s1_axis_yuv_tuser, s0_axis_yuv_tuser};
  assign lst = {s1_axis_yuv_tlast, s0_axis_yuv_tlast};
  assign req = sync_q & vld;

  assign s0_axis_yuv_tready = rdy[0];
  assign s1_axis_yuv_tready = rdy[1];
  assign drop_cnt0          = cnt0_q;
  assign drop_cnt1          = cnt1_q;

  always_comb begin
    state_d      = state_q;
    sync_d       = sync_q;
    last_grant_d = last_grant_q;
    rdy          = 2'b00;
    drop         = 2'b00;
    push_valid   = 1'b0;
    push_payload = {1'b0, s0_axis_yuv_tuser, s0_axis_yuv_tlast, s0_axis_yuv_tdata};

    // run_q keeps every tready low during reset and the first cycle after it.
    for (int i = 0; i < 2; i++) begin
      if (run_q && !sync_q[i]) begin
        rdy[i]  = !(vld[i] && usr[i]);
        drop[i] = vld[i] && !usr[i];
        if (vld[i] && usr[i]) sync_d[i] = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (req == 2'b11)  state_d = last_grant_q ? GRANT0 : GRANT1;
        else if (req[0])   state_d = GRANT0;
        else if (req[1])   state_d = GRANT1;
      end
      GRANT0: begin
        rdy[0]     = slice_ready;
        push_valid = vld[0] && slice_ready;
        if (push_valid && lst[0]) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end
      GRANT1: begin
        rdy[1]       = slice_ready;
        push_valid   = vld[1] && slice_ready;
        push_payload = {1'b1, s1_axis_yuv_tuser, s1_axis_yuv_tlast, s1_axis_yuv_tdata};
        if (push_valid && lst[1]) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cnt0_d = (drop[0] && cnt0_q != CntMax) ? cnt0_q + CNT_WIDTH'(1) : cnt0_q;
    cnt1_d = (drop[1] && cnt1_q != CntMax) ? cnt1_q + CNT_WIDTH'(1) : cnt1_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      sync_q       <= 2'b00;
      last_grant_q <= 1'b1;
      run_q        <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      last_grant_q <= last_grant_d;
      run_q        <= 1'b1;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  axis_reg_slice #(
    .Width(PW)
  ) u_slice (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_valid  (push_valid),
    .s_ready  (slice_ready),
    .s_payload(push_payload),
    .m_valid  (m_valid),
    .m_ready  (m_axis_yuv_tready),
    .m_payload(m_payload)
  );

  assign m_axis_yuv_tvalid = m_valid;
  assign m_axis_yuv_tdata  = m_payload[TW-1:0];
  assign m_axis_yuv_tlast  = m_payload[TW];
  assign m_axis_yuv_tuser  = m_payload[TW+1];
  assign m_axis_yuv_tdest  = m_payload[TW+2];

endmodule

// File: tb/tb_yuv_conv_arbiter.sv
// Scoreboard bench for yuv_conv_arbiter: per-source expected queues, output log for timing.
module tb_yuv_conv_arbiter;

  localparam int TW = 96;
  localparam int NSAT = 65536 + 5;

  typedef struct {
    int cyc;
    bit dest;
    bit user;
    bit last;
  } log_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [TW-1:0] s_tdata [2];
  logic          s_tvalid [2];
  logic          s_tuser [2];
  logic          s_tlast [2];
  logic          s0_rdy, s1_rdy;
  logic [TW-1:0] m_tdata;
  logic          m_tvalid, m_tuser, m_tlast, m_tdest;
  logic          m_tready;
  logic [15:0]   drop_cnt0, drop_cnt1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b1;
  bit rand_ready = 1'b0;
  bit in_line = 1'b0;
  bit owner = 1'b0;
  bit prev_stall = 1'b0;
  logic [TW+1:0] prev_word;
  bit prev_dest;
  logic [TW+1:0] exp0[$];
  logic [TW+1:0] exp1[$];
  log_t log_q[$];

  yuv_conv_arbiter dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s0_axis_yuv_tdata (s_tdata[0]),
    .s0_axis_yuv_tvalid(s_tvalid[0]),
    .s0_axis_yuv_tuser (s_tuser[0]),
    .s0_axis_yuv_tlast (s_tlast[0]),
    .s0_axis_yuv_tready(s0_rdy),
    .s1_axis_yuv_tdata (s_tdata[1]),
    .s1_axis_yuv_tvalid(s_tvalid[1]),
    .s1_axis_yuv_tuser (s_tuser[1]),
    .s1_axis_yuv_tlast (s_tlast[1]),
    .s1_axis_yuv_tready(s1_rdy),
    .m_axis_yuv_tdata  (m_tdata),
    .m_axis_yuv_tvalid (m_tvalid),
    .m_axis_yuv_tuser  (m_tuser),
    .m_axis_yuv_tlast  (m_tlast),
    .m_axis_yuv_tdest  (m_tdest),
    .m_axis_yuv_tready (m_tready),
    .drop_cnt0         (drop_cnt0),
    .drop_cnt1         (drop_cnt1)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    cyc++;
    #1 m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: handshake seen at the falling edge completes at the next rising edge.
  always @(negedge aclk) begin
    logic [TW+1:0] got;
    logic [TW+1:0] want;
    got = {m_tuser, m_tlast, m_tdata};
    if (aresetn && mon_en) begin
      if (prev_stall) begin
        checks++;
        if (m_tvalid !== 1'b1 || got !== prev_word || m_tdest !== prev_dest) begin
          failures++;
          $display("FAIL stall_stable: got v=%b dest=%b word=%h, required v=1 dest=%b word=%h",
                   m_tvalid, m_tdest, got, prev_dest, prev_word);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_word  = got;
      prev_dest  = m_tdest;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        log_q.push_back('{cyc: cyc, dest: m_tdest, user: m_tuser, last: m_tlast});
        checks++;
        if (in_line && m_tdest !== owner) begin
          failures++;
          $display("FAIL interleave: got tdest=%b mid-line, required %b", m_tdest, owner);
        end
        in_line = !m_tlast;
        owner   = m_tdest;
        checks++;
        if ((m_tdest ? exp1.size() : exp0.size()) == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got tdest=%b word=%h, required no beat", m_tdest, got);
        end else begin
          want = m_tdest ? exp1.pop_front() : exp0.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL beat_data: tdest=%b got %h, required %h", m_tdest, got, want);
          end
        end
      end
    end
  end

  task automatic send_beat(input int src, input logic [TW-1:0] d, input logic u,
                           input logic l, input bit expect_out);
    int t = 0;
    if (expect_out) begin
      if (src == 0) exp0.push_back({u, l, d});
      else exp1.push_back({u, l, d});
    end
    s_tdata[src]  = d;
    s_tuser[src]  = u;
    s_tlast[src]  = l;
    s_tvalid[src] = 1'b1;
    @(negedge aclk);
    while ((src == 0 ? s0_rdy : s1_rdy) !== 1'b1 && t < 1000) begin
      t++;
      @(negedge aclk);
    end
    checks++;
    if (t >= 1000) begin
      failures++;
      $display("FAIL handshake_timeout: src=%0d got no tready in %0d cycles, required tready", src, t);
    end
    @(posedge aclk);
    #1 s_tvalid[src] = 1'b0;
  endtask

  task automatic send_line(input int src, input int len, input bit user, input bit expect_out);
    for (int b = 0; b < len; b++)
      send_beat(src, {$urandom, $urandom, $urandom}, user && b == 0, b == len - 1, expect_out);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || m_tvalid) && t < 3000) begin
      @(posedge aclk);
      t++;
    end
    checks++;
    if (t >= 3000) begin
      failures++;
      $display("FAIL drain: got %0d/%0d beats still pending, required 0/0", exp0.size(), exp1.size());
    end
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_tvalid[i] = 1'b0;
      s_tuser[i]  = 1'b0;
      s_tlast[i]  = 1'b0;
      s_tdata[i]  = '0;
    end
    exp0.delete();
    exp1.delete();
    in_line    = 1'b0;
    prev_stall = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_tdata[i]  = '0;
      s_tuser[i]  = 1'b0;
      s_tlast[i]  = 1'b0;
    end
    s_tvalid[0] = 1'b1;
    s_tvalid[1] = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({s0_rdy, s1_rdy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_tready: got %b, required 00", {s0_rdy, s1_rdy});
    end
    checks++;
    if ({m_tvalid, m_tuser, m_tlast, m_tdest} !== 4'b0 || m_tdata !== '0) begin
      failures++;
      $display("FAIL reset_m_axis: got v/u/l/d=%b data=%h, required 0000 data=0",
               {m_tvalid, m_tuser, m_tlast, m_tdest}, m_tdata);
    end
    checks++;
    if (drop_cnt0 !== 16'd0 || drop_cnt1 !== 16'd0) begin
      failures++;
      $display("FAIL reset_drop_cnt: got %h/%h, required 0000/0000", drop_cnt0, drop_cnt1);
    end
    s_tvalid[0] = 1'b0;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_frame_align();
    log_q.delete();
    repeat (3) send_beat(0, {$urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    send_line(0, 4, 1'b1, 1'b1);
    drain();
    checks++;
    if (drop_cnt0 !== 16'd3) begin
      failures++;
      $display("FAIL align_drop_cnt0: got %0d, required 3", drop_cnt0);
    end
    checks++;
    if (log_q.size() != 4) begin
      failures++;
      $display("FAIL align_beats: got %0d output beats, required 4", log_q.size());
    end else begin
      checks++;
      if (log_q[0].user !== 1'b1 || log_q[0].dest !== 1'b0) begin
        failures++;
        $display("FAIL align_first: got tuser=%b tdest=%b, required tuser=1 tdest=0",
                 log_q[0].user, log_q[0].dest);
      end
    end
  endtask

  task automatic test_tie();
    send_line(1, 1, 1'b1, 1'b1);
    drain();
    log_q.delete();
    fork
      send_line(0, 4, 1'b0, 1'b1);
      send_line(1, 4, 1'b0, 1'b1);
    join
    drain();
    checks++;
    if (log_q.size() != 8) begin
      failures++;
      $display("FAIL tie_beats: got %0d output beats, required 8", log_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (log_q[i].dest !== (i >= 4) || log_q[i].last !== (i == 3 || i == 7)) begin
          failures++;
          $display("FAIL tie_order: beat %0d got tdest=%b tlast=%b, required tdest=%b tlast=%b",
                   i, log_q[i].dest, log_q[i].last, i >= 4, i == 3 || i == 7);
        end
      end
      checks++;
      if (log_q[4].cyc - log_q[3].cyc != 2 || log_q[1].cyc - log_q[0].cyc != 1) begin
        failures++;
        $display("FAIL tie_gap: got line gap %0d beat gap %0d, required 2 and 1",
                 log_q[4].cyc - log_q[3].cyc, log_q[1].cyc - log_q[0].cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    log_q.delete();
    repeat (3) send_line(0, 3, 1'b0, 1'b1);
    drain();
    checks++;
    if (log_q.size() != 9) begin
      failures++;
      $display("FAIL b2b_beats: got %0d output beats, required 9", log_q.size());
    end else begin
      for (int i = 1; i < 9; i++) begin
        checks++;
        if (log_q[i].dest !== 1'b0 || log_q[i].cyc - log_q[i-1].cyc != ((i % 3 == 0) ? 2 : 1)) begin
          failures++;
          $display("FAIL b2b_timing: beat %0d got tdest=%b gap=%0d, required tdest=0 gap=%0d",
                   i, log_q[i].dest, log_q[i].cyc - log_q[i-1].cyc, (i % 3 == 0) ? 2 : 1);
        end
      end
    end
    log_q.delete();
    fork
      send_line(0, 2, 1'b0, 1'b1);
      send_line(1, 2, 1'b0, 1'b1);
    join
    drain();
    checks++;
    if (log_q.size() != 4 || log_q[0].dest !== 1'b1) begin
      failures++;
      $display("FAIL b2b_rr: got %0d beats first tdest=%b, required 4 beats first tdest=1",
               log_q.size(), log_q.size() > 0 ? log_q[0].dest : 1'b0);
    end
  endtask

  task automatic test_random_backpressure();
    rand_ready = 1'b1;
    fork
      for (int n = 0; n < 50; n++)
        send_line(0, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b1);
      for (int n = 0; n < 50; n++)
        send_line(1, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b1);
    join
    drain();
    rand_ready = 1'b0;
    checks++;
    if (in_line) begin
      failures++;
      $display("FAIL random_end: got open line on tdest=%b, required closed", owner);
    end
  endtask

  task automatic test_saturate();
    int n = 0;
    int t = 0;
    apply_reset();
    fork
      begin
        s_tdata[1]  = {$urandom, $urandom, $urandom};
        s_tuser[1]  = 1'b0;
        s_tlast[1]  = 1'b0;
        s_tvalid[1] = 1'b1;
        while (n < NSAT && t < NSAT + 1000) begin
          @(negedge aclk);
          t++;
          if (s1_rdy === 1'b1) n++;
        end
        @(posedge aclk);
        #1 s_tvalid[1] = 1'b0;
      end
      begin
        send_line(0, 4, 1'b1, 1'b1);
        repeat (20) send_line(0, 4, 1'b0, 1'b1);
      end
    join
    drain();
    checks++;
    if (n != NSAT) begin
      failures++;
      $display("FAIL sat_accepts: got %0d s1 drops accepted, required %0d", n, NSAT);
    end
    checks++;
    if (drop_cnt1 !== 16'hFFFF || drop_cnt0 !== 16'd0) begin
      failures++;
      $display("FAIL sat_cnt: got drop_cnt1=%h drop_cnt0=%h, required ffff/0000", drop_cnt1, drop_cnt0);
    end
  endtask

  task automatic test_reset_midline();
    int n = 0;
    int t = 0;
    send_line(1, 1, 1'b1, 1'b1);
    drain();
    mon_en = 1'b0;
    s_tdata[1]  = {$urandom, $urandom, $urandom};
    s_tuser[1]  = 1'b0;
    s_tlast[1]  = 1'b0;
    s_tvalid[1] = 1'b1;
    while (n < 2 && t < 100) begin
      @(negedge aclk);
      t++;
      if (s1_rdy === 1'b1) n++;
    end
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, m_tuser, m_tlast, m_tdest} !== 4'b0 || m_tdata !== '0 ||
        {s0_rdy, s1_rdy} !== 2'b00 || drop_cnt1 !== 16'd0) begin
      failures++;
      $display("FAIL midline_reset: got v/u/l/d=%b rdy=%b cnt1=%h, required 0000 00 0000",
               {m_tvalid, m_tuser, m_tlast, m_tdest}, {s0_rdy, s1_rdy}, drop_cnt1);
    end
    s_tvalid[1] = 1'b0;
    exp0.delete();
    exp1.delete();
    in_line    = 1'b0;
    prev_stall = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    mon_en = 1'b1;
    log_q.delete();
    repeat (2) send_beat(1, {$urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge aclk);
    #1;
    checks++;
    if (log_q.size() != 0 || drop_cnt1 !== 16'd2) begin
      failures++;
      $display("FAIL resync_drop: got %0d beats cnt1=%0d, required 0 beats cnt1=2",
               log_q.size(), drop_cnt1);
    end
    send_line(1, 2, 1'b1, 1'b1);
    drain();
    checks++;
    if (log_q.size() != 2 || log_q[0].dest !== 1'b1 || log_q[0].user !== 1'b1) begin
      failures++;
      $display("FAIL resync_line: got %0d beats, required 2 beats tdest=1 first tuser=1",
               log_q.size());
    end
  endtask

  initial begin
    m_tready = 1'b1;
    test_reset();
    test_frame_align();
    test_tie();
    test_back_to_back();
    test_random_backpressure();
    test_saturate();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
